// File: rtl/ddc_phase_scheduler.sv
// ddc_phase_scheduler: shares one ddc_core across N_CH tones, with shadow/active phase banks and a tag line.
// Optional build macro DDC_SCHED_OVERRUN_CNT_EN enables the saturating dropped-sample counter.
module ddc_phase_scheduler #(
  parameter int N_CH    = 4,
  parameter int DDC_LAT = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adc_data,
  input  logic        adc_valid,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [19:0] cfg_pinc,
  input  logic [19:0] cfg_poff,
  input  logic        cfg_commit,
  output logic        commit_pend,
  output logic [31:0] ddc_data,
  output logic [47:0] ddc_phase,
  output logic        ddc_valid,
  output logic [3:0]  ddc_ch,
  output logic        tag_valid,
  output logic [3:0]  tag_ch,
  output logic        overrun,
  output logic [15:0] overrun_cnt
);

  // adc_valid is a one-cycle strobe with no back-pressure: one sample sweeps,
  // one waits in pending, and anything beyond that is dropped and flagged.

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  slot_q, slot_d;
  logic [31:0] act_q, act_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_full_q, pend_full_d;
  logic        valid_q;
  logic [47:0] phase_q, phase_d;
  logic        commit_pend_q;
  logic        overrun_q;
  logic        last_slot;
  logic        copy_now;
  logic        drop;

  logic [19:0] sh_pinc  [N_CH];
  logic [19:0] sh_poff  [N_CH];
  logic [19:0] act_pinc [N_CH];
  logic [19:0] act_poff [N_CH];
  logic [19:0] mrg_pinc [N_CH];
  logic [19:0] mrg_poff [N_CH];
  logic        wr_hit   [N_CH];

  logic [4:0]  tag_sr   [DDC_LAT];

  assign last_slot = (state_q == SWEEP) && (slot_q == 4'(N_CH - 1));
  assign copy_now  = commit_pend_q && ((state_q == IDLE) || last_slot);

  // Shadow contents as they will be after this cycle's write, so a copy taken
  // in the same cycle as a write carries the new value.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      wr_hit[i]   = cfg_we && (cfg_addr == 4'(i));
      mrg_pinc[i] = wr_hit[i] ? cfg_pinc : sh_pinc[i];
      mrg_poff[i] = wr_hit[i] ? cfg_poff : sh_poff[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    act_d       = act_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    drop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (adc_valid) begin
          act_d   = adc_data;
          state_d = SWEEP;
          slot_d  = 4'd0;
        end
      end
      SWEEP: begin
        if (last_slot) begin
          slot_d = 4'd0;
          if (pend_full_q) begin
            act_d       = pend_q;
            pend_full_d = adc_valid;
            if (adc_valid) begin
              pend_d = adc_data;
            end
          end else if (adc_valid) begin
            act_d = adc_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          slot_d = slot_q + 4'd1;
          if (adc_valid) begin
            if (pend_full_q) begin
              drop = 1'b1;
            end else begin
              pend_d      = adc_data;
              pend_full_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        slot_d  = 4'd0;
      end
    endcase
  end

  // Phase for the slot shown next cycle; a commit taken now applies to it.
  always_comb begin
    phase_d = '0;
    if (state_d == SWEEP) begin
      for (int i = 0; i < N_CH; i++) begin
        if (slot_d == 4'(i)) begin
          phase_d[19:0]  = copy_now ? mrg_pinc[i] : act_pinc[i];
          phase_d[43:24] = copy_now ? mrg_poff[i] : act_poff[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      slot_q        <= 4'd0;
      act_q         <= '0;
      pend_q        <= '0;
      pend_full_q   <= 1'b0;
      valid_q       <= 1'b0;
      phase_q       <= '0;
      commit_pend_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      valid_q     <= (state_d == SWEEP);
      phase_q     <= phase_d;
      if (cfg_commit) begin
        commit_pend_q <= 1'b1;
      end else if (copy_now) begin
        commit_pend_q <= 1'b0;
      end
      if (drop) begin
        overrun_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        sh_pinc[i]  <= '0;
        sh_poff[i]  <= '0;
        act_pinc[i] <= '0;
        act_poff[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        sh_pinc[i] <= mrg_pinc[i];
        sh_poff[i] <= mrg_poff[i];
        if (copy_now) begin
          act_pinc[i] <= mrg_pinc[i];
          act_poff[i] <= mrg_poff[i];
        end
      end
    end
  end

  // Channel tag travels alongside the core's pipeline so results can be demuxed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DDC_LAT; i++) begin
        tag_sr[i] <= '0;
      end
    end else begin
      tag_sr[0] <= {valid_q, slot_q};
      for (int i = 1; i < DDC_LAT; i++) begin
        tag_sr[i] <= tag_sr[i-1];
      end
    end
  end

`ifdef DDC_SCHED_OVERRUN_CNT_EN
  logic [15:0] ovr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_cnt_q <= '0;
    end else if (drop && (ovr_cnt_q != 16'hFFFF)) begin
      ovr_cnt_q <= ovr_cnt_q + 16'd1;
    end
  end

  assign overrun_cnt = ovr_cnt_q;
`else
  assign overrun_cnt = 16'h0000;
`endif

  assign commit_pend = commit_pend_q;
  assign ddc_data    = act_q;
  assign ddc_phase   = phase_q;
  assign ddc_valid   = valid_q;
  assign ddc_ch      = slot_q;
  assign tag_valid   = tag_sr[DDC_LAT-1][4];
  assign tag_ch      = tag_sr[DDC_LAT-1][3:0];
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_ddc_phase_scheduler.sv
// Bench for ddc_phase_scheduler: directed test-plan steps, then random traffic against a queue-based model.
module tb_ddc_phase_scheduler;
  localparam int N_CH    = 4;
  localparam int DDC_LAT = 14;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adc_data;
  logic        adc_valid;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [19:0] cfg_pinc;
  logic [19:0] cfg_poff;
  logic        cfg_commit;
  logic        commit_pend;
  logic [31:0] ddc_data;
  logic [47:0] ddc_phase;
  logic        ddc_valid;
  logic [3:0]  ddc_ch;
  logic        tag_valid;
  logic [3:0]  tag_ch;
  logic        overrun;
  logic [15:0] overrun_cnt;

  always #5 clk = ~clk;

  ddc_phase_scheduler #(.N_CH(N_CH), .DDC_LAT(DDC_LAT)) dut (
    .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_pinc(cfg_pinc), .cfg_poff(cfg_poff),
    .cfg_commit(cfg_commit), .commit_pend(commit_pend), .ddc_data(ddc_data),
    .ddc_phase(ddc_phase), .ddc_valid(ddc_valid), .ddc_ch(ddc_ch),
    .tag_valid(tag_valid), .tag_ch(tag_ch), .overrun(overrun), .overrun_cnt(overrun_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: samples waiting to be swept (front = being swept now).
  logic [31:0] work_q[$];
  bit          m_busy;
  int          m_slot;
  bit          m_cp;
  bit          m_ovr;
  logic [15:0] m_cnt;
  logic [19:0] sh_pinc [N_CH];
  logic [19:0] sh_poff [N_CH];
  logic [19:0] a_pinc  [N_CH];
  logic [19:0] a_poff  [N_CH];
  logic [4:0]  exp_q[$];
  logic [4:0]  exp_tag;

  logic [31:0] b2b [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit copied;
    int idx;
    if (rst) begin
      work_q.delete();
      m_busy = 0; m_slot = 0; m_cp = 0; m_ovr = 0; m_cnt = '0;
      for (int i = 0; i < N_CH; i++) begin
        sh_pinc[i] = '0; sh_poff[i] = '0; a_pinc[i] = '0; a_poff[i] = '0;
      end
      exp_q.delete();
      for (int i = 0; i < DDC_LAT - 1; i++) exp_q.push_back(5'd0);
      exp_tag = 5'd0;
      return;
    end
    exp_q.push_back({m_busy, 4'(m_slot)});
    exp_tag = exp_q.pop_front();
    copied = m_cp && (!m_busy || m_slot == N_CH - 1);
    idx = int'(cfg_addr);
    if (cfg_we && idx < N_CH) begin
      sh_pinc[idx] = cfg_pinc;
      sh_poff[idx] = cfg_poff;
    end
    if (copied) begin
      for (int i = 0; i < N_CH; i++) begin
        a_pinc[i] = sh_pinc[i]; a_poff[i] = sh_poff[i];
      end
    end
    m_cp = cfg_commit ? 1'b1 : (copied ? 1'b0 : m_cp);
    if (!m_busy) begin
      if (adc_valid) begin
        work_q.delete();
        work_q.push_back(adc_data);
        m_busy = 1; m_slot = 0;
      end
    end else if (m_slot < N_CH - 1) begin
      m_slot++;
      if (adc_valid) begin
        if (work_q.size() < 2) work_q.push_back(adc_data);
        else begin
          m_ovr = 1;
`ifdef DDC_SCHED_OVERRUN_CNT_EN
          if (m_cnt != 16'hFFFF) m_cnt++;
`endif
        end
      end
    end else begin
      void'(work_q.pop_front());
      if (adc_valid) work_q.push_back(adc_data);
      m_slot = 0;
      m_busy = (work_q.size() > 0);
    end
  endtask

  task automatic compare();
    check("ddc_valid", ddc_valid, m_busy);
    if (m_busy) begin
      check("ddc_ch", ddc_ch, 4'(m_slot));
      check("ddc_data", ddc_data, work_q[0]);
      check("ddc_phase", ddc_phase, {4'h0, a_poff[m_slot], 4'h0, a_pinc[m_slot]});
    end
    check("tag_valid", tag_valid, exp_tag[4]);
    if (exp_tag[4]) check("tag_ch", tag_ch, exp_tag[3:0]);
    check("commit_pend", commit_pend, m_cp);
    check("overrun", overrun, m_ovr);
    check("overrun_cnt", overrun_cnt, m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    compare();
    adc_valid  = 1'b0;
    cfg_we     = 1'b0;
    cfg_commit = 1'b0;
  endtask

  initial begin
    int nval;
    int s4_seen;
    rst = 1'b1; adc_data = '0; adc_valid = 1'b0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_pinc = '0; cfg_poff = '0; cfg_commit = 1'b0;
    b2b[0] = 32'hA000_0001; b2b[1] = 32'hA000_0002; b2b[2] = 32'hA000_0003; b2b[3] = 32'hDEAD_0004;

    // Reset state
    tick(); tick();
    check("rst_ddc_valid", ddc_valid, 1'b0);
    check("rst_ddc_data", ddc_data, 32'h0);
    check("rst_ddc_phase", ddc_phase, 48'h0);
    check("rst_ddc_ch", ddc_ch, 4'h0);
    check("rst_tag_valid", tag_valid, 1'b0);
    check("rst_commit_pend", commit_pend, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_overrun_cnt", overrun_cnt, 16'h0);
    rst = 1'b0;

    // Single sweep
    for (int k = 0; k < N_CH; k++) begin
      cfg_we = 1'b1; cfg_addr = 4'(k); cfg_pinc = 20'(256 * (k + 1)); cfg_poff = 20'h0;
      tick();
    end
    cfg_commit = 1'b1; tick();
    check("ss_commit_set", commit_pend, 1'b1);
    tick();
    check("ss_commit_idle_clear", commit_pend, 1'b0);
    adc_valid = 1'b1; adc_data = 32'h1234_0567; tick();
    for (int k = 0; k < N_CH; k++) begin
      check("ss_valid", ddc_valid, 1'b1);
      check("ss_ch", ddc_ch, 4'(k));
      check("ss_pinc", ddc_phase[19:0], 20'(256 * (k + 1)));
      check("ss_data", ddc_data, 32'h1234_0567);
      tick();
    end
    check("ss_end_valid", ddc_valid, 1'b0);
    repeat (DDC_LAT - N_CH) tick();
    for (int k = 0; k < N_CH; k++) begin
      check("ss_tag_valid", tag_valid, 1'b1);
      check("ss_tag_ch", tag_ch, 4'(k));
      tick();
    end
    check("ss_tag_end", tag_valid, 1'b0);
    repeat (4) tick();

    // Back-to-back samples, fourth one overruns
    nval = 0; s4_seen = 0;
    for (int c = 0; c < 14; c++) begin
      if ((c % 2 == 0) && c <= 6) begin
        adc_valid = 1'b1; adc_data = b2b[c / 2];
      end
      tick();
      if (ddc_valid) begin
        nval++;
        if (ddc_data === b2b[3]) s4_seen++;
      end
      if (c == 5) check("b2b_no_overrun_yet", overrun, 1'b0);
      if (c == 6) check("b2b_overrun", overrun, 1'b1);
    end
    check("b2b_valid_slots", nval, 12);
    check("b2b_dropped_never_seen", s4_seen, 0);
`ifdef DDC_SCHED_OVERRUN_CNT_EN
    check("b2b_overrun_cnt", overrun_cnt, 16'd1);
`else
    check("b2b_overrun_cnt", overrun_cnt, 16'd0);
`endif
    repeat (4) tick();

    // Commit during sweep
    adc_valid = 1'b1; adc_data = 32'h0BAD_0001; tick();
    tick();
    adc_valid = 1'b1; adc_data = 32'h0BAD_0002;
    cfg_we = 1'b1; cfg_addr = 4'd2; cfg_pinc = 20'hABCDE; cfg_poff = 20'h12345; cfg_commit = 1'b1;
    tick();
    check("cds_old_ch2", ddc_phase, 48'h0000_0000_0300);
    check("cds_pend_slot2", commit_pend, 1'b1);
    tick();
    check("cds_pend_slot3", commit_pend, 1'b1);
    tick();
    check("cds_pend_cleared", commit_pend, 1'b0);
    tick(); tick();
    check("cds_new_ch2", ddc_phase, {4'h0, 20'h12345, 4'h0, 20'hABCDE});
    repeat (5) tick();

    // Write to a nonexistent channel, then commit
    cfg_we = 1'b1; cfg_addr = 4'd5; cfg_pinc = 20'hFFFFF; cfg_poff = 20'hFFFFF; cfg_commit = 1'b1;
    tick(); tick();
    adc_valid = 1'b1; adc_data = 32'h5555_0AAA; tick();
    check("ign_ch0", ddc_phase, 48'h0000_0000_0100);
    tick();
    check("ign_ch1", ddc_phase, 48'h0000_0000_0200);
    tick();
    check("ign_ch2", ddc_phase, {4'h0, 20'h12345, 4'h0, 20'hABCDE});
    tick();
    check("ign_ch3", ddc_phase, 48'h0000_0000_0400);
    repeat (4) tick();

    // Reset mid-sweep
    adc_valid = 1'b1; adc_data = 32'h7777_0111; tick();
    tick(); tick();
    rst = 1'b1; tick();
    check("rmid_valid", ddc_valid, 1'b0);
    check("rmid_overrun", overrun, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < DDC_LAT; k++) begin
      tick();
      check("rmid_tag_quiet", tag_valid, 1'b0);
    end
    adc_valid = 1'b1; adc_data = 32'h0101_0202; tick();
    for (int k = 0; k < N_CH; k++) begin
      check("rmid_active_zero", ddc_phase, 48'h0);
      tick();
    end
    cfg_commit = 1'b1; tick(); tick();
    adc_valid = 1'b1; adc_data = 32'h0303_0404; tick();
    for (int k = 0; k < N_CH; k++) begin
      check("rmid_shadow_zero", ddc_phase, 48'h0);
      tick();
    end
    repeat (3) tick();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 299) == 0);
      adc_valid  = ($urandom_range(0, 2) == 0);
      adc_data   = $urandom();
      cfg_we     = ($urandom_range(0, 3) == 0);
      cfg_addr   = 4'($urandom_range(0, 15));
      cfg_pinc   = 20'($urandom());
      cfg_poff   = 20'($urandom());
      cfg_commit = ($urandom_range(0, 9) == 0);
      tick();
    end
    rst = 1'b0;
    repeat (DDC_LAT + N_CH + 2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ddc_phase_scheduler.md
# ddc_phase_scheduler

Time-multiplexes one `ddc_core` instance across `N_CH` tones. For each ADC sample it sweeps the channel slots and presents the same sample to the core once per slot, each time with that channel's DDS phase word. It also keeps a per-channel shadow/active phase-register bank with sweep-boundary commit. A channel-tag delay line re-aligns the channel index with `ddc_core`'s `valid_out` and `ddc_out`.

## Interface
Parameters:
- `N_CH`, 4 — number of tone channels (2..16).
- `DDC_LAT`, 14 — cycles from `ddc_core` `valid_in` to `valid_out`.

Ports. Clock is `clk`; reset is `rst`, one clock domain, reset synchronous and active-high.
- `clk`  in  1  — system clock.
- `rst`  in  1  — synchronous, active-high reset.
- `adc_data`  in  32  — sample: [29:16] Q, [13:0] I.
- `adc_valid`  in  1  — sample strobe.
- `cfg_we`  in  1  — shadow-register write strobe.
- `cfg_addr`  in  4  — target channel; writes with `cfg_addr >= N_CH` are ignored.
- `cfg_pinc`  in  20  — phase increment.
- `cfg_poff`  in  20  — phase offset.
- `cfg_commit`  in  1  — request copy of shadow bank to active bank.
- `commit_pend`  out  1  — commit requested, not yet applied.
- `ddc_data`  out  32  — to `ddc_core` `data_in`.
- `ddc_phase`  out  48  — to `ddc_core` `phase_in`: pinc in [19:0], poff in [43:24], all other bits 0.
- `ddc_valid`  out  1  — to `ddc_core` `valid_in`.
- `ddc_ch`  out  4  — channel of the current slot.
- `tag_valid`  out  1  — `ddc_valid` delayed `DDC_LAT` cycles.
- `tag_ch`  out  4  — `ddc_ch` delayed `DDC_LAT` cycles.
- `overrun`  out  1  — sticky dropped-sample flag; cleared only by `rst`.
- `overrun_cnt`  out  16  — dropped-sample count (see Configuration).

## Operation
- **Reset values:** all outputs 0; shadow and active banks 0; FSM in IDLE; sample registers empty.
- **FSM states:** IDLE, SWEEP. A slot counter `slot` runs 0..N_CH-1.
- **IDLE:**
  - `adc_valid=1` latches `adc_data` into the active sample register.
  - Next state is SWEEP with `slot=0`.
- **SWEEP, each cycle:**
  - `ddc_valid=1`, `ddc_data` = active sample, `ddc_ch` = `slot`.
  - `ddc_phase` = the active bank entry for `slot`.
  - `slot` increments.
- **`adc_valid` during SWEEP:**
  - If the one-deep pending register is empty, the sample goes to pending.
  - If pending is full, the new sample is dropped, `overrun` is set and the counter increments. The pending sample is kept.
- **Last slot (`slot=N_CH-1`):**
  - Pending full: pending moves to active, next state SWEEP with `slot=0`, no bubble. A simultaneous `adc_valid` fills pending and is not an overrun.
  - Pending empty and `adc_valid=1`: latch into active, continue SWEEP with `slot=0`.
  - Otherwise: go to IDLE.
- **Configuration writes:**
  - `cfg_we` writes shadow[`cfg_addr`] at any time. The active bank is never affected by `cfg_we`.
  - `cfg_commit` sets `commit_pend`.
  - While `commit_pend` is set, the shadow bank is copied to the active bank in the first cycle that is IDLE or the last slot of a sweep, and `commit_pend` clears.
  - The next sweep therefore uses new values for all channels. No sweep ever mixes old and new values.
  - Commit in the same cycle as `cfg_we`: the copy includes the new write.
- **Tag delay line:** a shift register `DDC_LAT` deep carrying {`ddc_valid`, `ddc_ch`}, reset to 0.

## Timing
- `adc_valid` at cycle t in IDLE → `ddc_valid` high for cycles t+1..t+N_CH, with `ddc_ch` = 0..N_CH-1.
- `tag_valid` and `tag_ch` follow `ddc_valid` and `ddc_ch` by exactly `DDC_LAT` cycles.
- Maximum lossless sample rate is one sample per N_CH cycles. Up to one extra sample is absorbed per sweep by the pending register.
- `rst` mid-sweep aborts the sweep at the next edge:
  - `ddc_valid=0`, pending discarded.
  - Both banks zeroed and the tag line flushed.
  - `overrun` cleared.
- All outputs are registered.

## Configuration
- `DDC_SCHED_OVERRUN_CNT_EN` defined:
  - `overrun_cnt` is a 16-bit saturating count of dropped samples, reset to 0.
  - The count holds at 0xFFFF.
- Undefined: `overrun_cnt` is tied to 0 and no counter logic is built. The `overrun` flag still works.

## Test plan
- **Single sweep:** N_CH=4; shadow ch0..3 pinc = 0x00100, 0x00200, 0x00300, 0x00400; commit; one `adc_valid` with data 0x1234_0567.
  - Expect 4 consecutive `ddc_valid` cycles, `ddc_ch` 0..3, `ddc_phase[19:0]` matching each pinc, `ddc_data`=0x1234_0567.
  - Expect `tag_ch` 0..3 exactly 14 cycles later.
- **Back-to-back samples:** samples spaced 2 cycles apart, 3 samples.
  - Expect 12 contiguous valid slots with no bubble and no overrun.
  - A 4th sample while pending is full sets `overrun=1` and `overrun_cnt=1`; that sample never appears on `ddc_data`.
- **Commit during sweep:** write ch2 pinc=0xABCDE and commit at slot 1.
  - Expect the current sweep ch2 to keep the old value and the next sweep ch2 to use 0xABCDE; `commit_pend` drops at the last slot.
- **Ignored write:** `cfg_we` with `cfg_addr=5` at N_CH=4, then commit.
  - Expect the active bank unchanged.
- **Reset mid-sweep:** assert `rst` at slot 2.
  - Expect `ddc_valid=0` next cycle and all banks reading 0.
  - Expect `tag_valid` to stay 0 for the following `DDC_LAT` cycles.
